tx_gearbox_ser: RTL and testbench

Single-clock, parametrised multi-lane TX gearbox that sits between the link-layer datapath and the per-lane tree serializers. It accepts one IN_W-bit word per lane through a valid/ready handshake and emits OUT_W-bit slices per lane every cycle, with no gaps while the source keeps up. It adds:
- selectable LSB/MSB-first bit order;
- idle-pattern insertion on underrun;
- a saturating gap counter for link diagnostics.

---
 rtl/tx_gearbox_ser_if.sv | 24 ++
 rtl/tx_gearbox_ser.sv | 148 ++++++++++++++
 tb/tb_tx_gearbox_ser.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/tx_gearbox_ser_if.sv
// Word-in / slice-out bus of the TX gearbox: lane-packed words in, lane-packed slices out.
// The source drives the master side; the gearbox takes the slave side.
interface tx_gearbox_ser_if #(
  parameter int LANES = 4,
  parameter int IN_W  = 32,
  parameter int OUT_W = 2
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic                   in_msb_first;
  logic [LANES*OUT_W-1:0] out_data;
  logic                   out_valid;

  modport master (
    output in_valid, in_data, in_msb_first,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_valid, in_data, in_msb_first,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/tx_gearbox_ser.sv
// Multi-lane word-to-slice TX gearbox with idle fill and gap counter; first slice one edge after handshake.
// Backpressure: registered in_ready = !hold_full; a shifter plus one hold word keep the slice stream gap-free.
module tx_gearbox_ser #(
  parameter int LANES     = 4,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 2,
  parameter int GAP_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  tx_gearbox_ser_if.slave      bus,
  input  logic [OUT_W-1:0]     idle_pattern,
  input  logic                 gap_clr,
  output logic [GAP_CNT_W-1:0] gap_cnt
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  if (IN_W % OUT_W != 0) begin : g_bad_ratio
    $error("tx_gearbox_ser: OUT_W must divide IN_W");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [LANES*IN_W-1:0]  shift_q, shift_d, hold_q, hold_d;
  logic                   shift_msb_q, shift_msb_d, hold_msb_q, hold_msb_d;
  logic                   hold_full_q, hold_full_d;
  logic                   ready_q;
  logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic [GAP_CNT_W-1:0]   gap_q;
  logic                   seen_q;
  logic                   hs;

  assign hs            = bus.in_valid && ready_q;
  assign bus.in_ready  = ready_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign gap_cnt       = gap_q;

  // MSB-first is handled by bit-reversing each lane word, so both orders share one extractor.
  function automatic logic [LANES*OUT_W-1:0] slice_of(input logic [LANES*IN_W-1:0] w,
                                                      input logic msb,
                                                      input logic [CNT_W-1:0] idx);
    logic [LANES*OUT_W-1:0] r;
    logic [IN_W-1:0]        lw, rv, sh;
    r = '0;
    for (int n = 0; n < LANES; n++) begin
      lw = w[n*IN_W +: IN_W];
      rv = lw;
      if (msb) begin
        for (int k = 0; k < IN_W; k++) rv[k] = lw[IN_W-1-k];
      end
      sh = rv >> (int'(idx) * OUT_W);
      r[n*OUT_W +: OUT_W] = sh[OUT_W-1:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    shift_msb_d = shift_msb_q;
    hold_d      = hold_q;
    hold_msb_d  = hold_msb_q;
    hold_full_d = hold_full_q;
    out_valid_d = 1'b0;
    out_data_d  = {LANES{idle_pattern}};
    case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d     = bus.in_data;
          shift_msb_d = bus.in_msb_first;
          out_data_d  = slice_of(bus.in_data, bus.in_msb_first, '0);
          out_valid_d = 1'b1;
          // With a single slice per word the word is fully emitted here, so the shifter stays empty.
          cnt_d       = (RATIO == 1) ? '0 : CNT_W'(1);
          state_d     = (RATIO == 1) ? IDLE : RUN;
        end
      end
      RUN: begin
        out_data_d  = slice_of(shift_q, shift_msb_q, cnt_q);
        out_valid_d = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (hold_full_q) begin
            shift_d     = hold_q;
            shift_msb_d = hold_msb_q;
            hold_full_d = 1'b0;
          end else if (hs) begin
            shift_d     = bus.in_data;
            shift_msb_d = bus.in_msb_first;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (hs) begin
            hold_d      = bus.in_data;
            hold_msb_d  = bus.in_msb_first;
            hold_full_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      shift_msb_q <= 1'b0;
      hold_q      <= '0;
      hold_msb_q  <= 1'b0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      gap_q       <= '0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      shift_msb_q <= shift_msb_d;
      hold_q      <= hold_d;
      hold_msb_q  <= hold_msb_d;
      hold_full_q <= hold_full_d;
      ready_q     <= !hold_full_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      // Gaps only count once data has flowed, so link bring-up idle does not pollute diagnostics.
      if (gap_clr) begin
        gap_q  <= '0;
        seen_q <= out_valid_d;
      end else if (out_valid_d) begin
        seen_q <= 1'b1;
      end else if (seen_q && (gap_q != '1)) begin
        gap_q <= gap_q + GAP_CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_tx_gearbox_ser.sv
// Scoreboard bench for tx_gearbox_ser (2 lanes, 8-bit words, 2-bit slices) plus a 3-bit gap counter instance.
module tb_tx_gearbox_ser;
  localparam int LANES = 2;
  localparam int IN_W  = 8;
  localparam int OUT_W = 2;
  localparam int RATIO = IN_W / OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [OUT_W-1:0] idle_pattern;
  logic             gap_clr;
  logic [15:0]      gap_cnt;
  logic [2:0]       gap_cnt_s;

  tx_gearbox_ser_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();
  tx_gearbox_ser_if #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W)) bus_s ();

  tx_gearbox_ser #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .GAP_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .idle_pattern(idle_pattern),
    .gap_clr(gap_clr), .gap_cnt(gap_cnt)
  );

  tx_gearbox_ser #(.LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .GAP_CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .idle_pattern(idle_pattern),
    .gap_clr(gap_clr), .gap_cnt(gap_cnt_s)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [LANES*OUT_W-1:0] sb[$];
  int idle_beats = 0;
  int stalls     = 0;
  int beats      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] ref_slice(input logic [IN_W-1:0] w, input logic msb, input int i);
    logic [OUT_W-1:0] s;
    for (int j = 0; j < OUT_W; j++) begin
      s[j] = msb ? w[IN_W-1-(i*OUT_W+j)] : w[i*OUT_W+j];
    end
    return s;
  endfunction

  task automatic push_word(input logic [LANES*IN_W-1:0] w, input logic msb);
    logic [LANES*OUT_W-1:0] e;
    for (int i = 0; i < RATIO; i++) begin
      for (int n = 0; n < LANES; n++) e[n*OUT_W +: OUT_W] = ref_slice(w[n*IN_W +: IN_W], msb, i);
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send(input logic [LANES*IN_W-1:0] w, input logic msb);
    int g = 0;
    bus.in_valid     = 1'b1;
    bus.in_data      = w;
    bus.in_msb_first = msb;
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    push_word(w, msb);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    chk(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid === 1'b1) begin
        beats++;
        if (sb.size() == 0) chk("unexpected_beat", bus.out_valid, 0);
        else chk("slice", bus.out_data, sb.pop_front());
      end else begin
        idle_beats++;
        if (sb.size() != 0) stalls++;
      end
    end
  end

  initial begin
    int s0, b0, ib0;
    logic [LANES*IN_W-1:0] w;
    rst = 1'b1;
    idle_pattern = 2'b10;
    gap_clr = 1'b0;
    bus.in_valid = 1'b0;   bus.in_data = '0;   bus.in_msb_first = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_msb_first = 1'b0;

    // Reset release
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_gap_cnt", gap_cnt, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_idle_data", bus.out_data, 4'b1010);
    chk("rel_out_valid", bus.out_valid, 0);

    // Single word, LSB first
    send({8'h1E, 8'hB4}, 1'b0);
    chk("lsb_s0", bus.out_data, 4'h8);
    @(negedge clk); chk("lsb_s1", bus.out_data, 4'hD);
    @(negedge clk); chk("lsb_s2", bus.out_data, 4'h7);
    @(negedge clk); chk("lsb_s3", bus.out_data, 4'h2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lsb_gap_cnt", gap_cnt, k);
      chk("lsb_idle_data", bus.out_data, 4'b1010);
    end

    // MSB first, order input flips while the word is in flight
    send({8'h1E, 8'hB4}, 1'b1);
    chk("msb_s0", bus.out_data, 4'h1);
    send({8'h3C, 8'hB4}, 1'b0);
    chk("msb_s1", bus.out_data, 4'hB);
    @(negedge clk); chk("msb_s2", bus.out_data, 4'hE);
    @(negedge clk); chk("msb_s3", bus.out_data, 4'h4);
    drain("msb_drain");

    // Back-to-back stream of 16 random words
    @(negedge clk); gap_clr = 1'b1;
    @(negedge clk); gap_clr = 1'b0;
    chk("b2b_gap_clr", gap_cnt, 0);
    b0 = beats;
    send(16'($urandom), 1'($urandom_range(0, 1)));
    s0 = stalls;
    for (int k = 1; k < 16; k++) begin
      w = 16'($urandom);
      send(w, 1'($urandom_range(0, 1)));
    end
    drain("b2b_drain");
    chk("b2b_gap_cnt", gap_cnt, 0);
    chk("b2b_stalls", stalls - s0, 0);
    chk("b2b_beats", beats - b0, 64);

    // Underrun: word, five idle beats, word
    @(negedge clk); gap_clr = 1'b1;
    @(negedge clk); gap_clr = 1'b0;
    send({8'h5A, 8'hC3}, 1'b0);
    repeat (3) @(negedge clk);
    ib0 = idle_beats;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("und_idle", bus.out_valid, 0);
    end
    chk("und_gap_cnt", gap_cnt, 5);
    send({8'h81, 8'h7E}, 1'b1);
    chk("und_idle_beats", idle_beats - ib0, 5);
    drain("und_drain");
    @(negedge clk);
    gap_clr = 1'b1;
    @(negedge clk);
    gap_clr = 1'b0;
    chk("clr_gap_cnt", gap_cnt, 0);
    chk("clr_idle", bus.out_valid, 0);

    // Saturation on the 3-bit counter instance
    chk("sat_in_ready", bus_s.in_ready, 1);
    bus_s.in_valid = 1'b1;
    bus_s.in_data  = 16'hA55A;
    @(negedge clk);
    bus_s.in_valid = 1'b0;
    repeat (3 + 7) @(negedge clk);
    chk("sat_gap7", gap_cnt_s, 7);
    repeat (3) @(negedge clk);
    chk("sat_gap10", gap_cnt_s, 7);

    // Reset mid-word with the hold stage full
    send({8'hF0, 8'h0F}, 1'b0);
    send({8'hCC, 8'h33}, 1'b0);
    chk("mid_hold_full", bus.in_ready, 0);
    #1;
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", bus.in_ready, 1);
    chk("mid_rel_valid", bus.out_valid, 0);
    send({8'h96, 8'h69}, 1'b1);
    drain("mid_drain");
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
